// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the clock display back-end: segment patterns,
// digit index type and converter state encoding.
package clock_disp_pkg;

   typedef logic [1:0] digit_idx_t;

   typedef enum logic [1:0] {
      CONV_IDLE   = 2'b00,
      CONV_LOAD   = 2'b01,
      CONV_DIV    = 2'b11,
      CONV_COMMIT = 2'b10
   } conv_state_t;

   // Active-high patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational digit decoder: 4-bit code plus blank request to an active-high
// 7-segment pattern. Codes above 9 decode to blank.
module bcd_seg_decoder
   import clock_disp_pkg::*;
(
   input  logic [3:0] code,
   input  logic       blank,
   output logic [6:0] pattern
);

   always_comb begin
      // NOTE: assign the output a default before any branch so no path can infer a latch.
      pattern = SEG_BLANK;
      if (!blank) begin
         case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/clock_display_driver.sv
// Display back-end of the digital clock: per-frame binary-to-digit conversion
// and a time-multiplexed 4-digit 7-segment scan with a blinking colon.
module clock_display_driver
   import clock_disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter int unsigned COLON_DIV      = 25000000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] hours_fsm,
   input  logic [5:0] minutes_fsm,
   input  logic       disp_en,
   input  logic       blink_en,
   input  logic       lz_blank,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       conv_busy
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int COL_W = (COLON_DIV > 1) ? $clog2(COLON_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLON_DIV - 1);
   // Inactive output levels double as the polarity XOR masks
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

   logic [REF_W-1:0] refresh_cnt_q, refresh_cnt_d;
   digit_idx_t       idx_q, idx_d;
   logic [COL_W-1:0] colon_cnt_q, colon_cnt_d;
   logic             colon_on_q, colon_on_d;
   conv_state_t      state_q, state_d;
   logic [5:0]       lat_h_q, lat_h_d, lat_m_q, lat_m_d;
   logic [5:0]       work_h_q, work_h_d, work_m_q, work_m_d;
   logic [2:0]       tens_h_q, tens_h_d, tens_m_q, tens_m_d;
   logic [2:0]       dig_h_tens_q, dig_h_tens_d, dig_m_tens_q, dig_m_tens_d;
   logic [3:0]       dig_h_units_q, dig_h_units_d, dig_m_units_q, dig_m_units_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;

   logic       tick, frame_start;
   logic [3:0] mux_code;
   logic       mux_blank;
   logic [6:0] mux_pattern;

   assign tick        = (refresh_cnt_q == REF_LAST);
   assign frame_start = tick && (idx_q == 2'd3);

   always_comb begin
      refresh_cnt_d = tick ? '0 : refresh_cnt_q + REF_W'(1);
      idx_d         = tick ? idx_q + 2'd1 : idx_q;

      colon_cnt_d = colon_cnt_q + COL_W'(1);
      colon_on_d  = colon_on_q;
      if (!blink_en) begin
         colon_cnt_d = '0;
         colon_on_d  = 1'b1;
      end else if (colon_cnt_q == COL_LAST) begin
         colon_cnt_d = '0;
         colon_on_d  = ~colon_on_q;
      end
   end

   always_comb begin
      state_d       = state_q;
      lat_h_d       = lat_h_q;
      lat_m_d       = lat_m_q;
      work_h_d      = work_h_q;
      work_m_d      = work_m_q;
      tens_h_d      = tens_h_q;
      tens_m_d      = tens_m_q;
      dig_h_tens_d  = dig_h_tens_q;
      dig_h_units_d = dig_h_units_q;
      dig_m_tens_d  = dig_m_tens_q;
      dig_m_units_d = dig_m_units_q;
      case (state_q)
         CONV_IDLE: begin
            if (frame_start) begin
               lat_h_d = hours_fsm;
               lat_m_d = minutes_fsm;
               state_d = CONV_LOAD;
            end
         end
         CONV_LOAD: begin
            work_h_d = lat_h_q;
            work_m_d = lat_m_q;
            tens_h_d = '0;
            tens_m_d = '0;
            state_d  = CONV_DIV;
         end
         CONV_DIV: begin
            if (work_h_q >= 6'd10) begin
               work_h_d = work_h_q - 6'd10;
               tens_h_d = tens_h_q + 3'd1;
            end
            if (work_m_q >= 6'd10) begin
               work_m_d = work_m_q - 6'd10;
               tens_m_d = tens_m_q + 3'd1;
            end
            // Look ahead at the post-subtraction values so 63 needs only six DIV cycles
            if ((work_h_d < 6'd10) && (work_m_d < 6'd10)) state_d = CONV_COMMIT;
         end
         CONV_COMMIT: begin
            dig_h_tens_d  = tens_h_q;
            dig_h_units_d = work_h_q[3:0];
            dig_m_tens_d  = tens_m_q;
            dig_m_units_d = work_m_q[3:0];
            state_d       = CONV_IDLE;
         end
      endcase
   end

   always_comb begin
      case (idx_q)
         2'd0:    mux_code = dig_m_units_q;
         2'd1:    mux_code = {1'b0, dig_m_tens_q};
         2'd2:    mux_code = dig_h_units_q;
         default: mux_code = {1'b0, dig_h_tens_q};
      endcase
      mux_blank = (idx_q == 2'd3) && lz_blank && (dig_h_tens_q == 3'd0);
   end

   bcd_seg_decoder u_dec (
      .code    (mux_code),
      .blank   (mux_blank),
      .pattern (mux_pattern)
   );

   always_comb begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
      dp_d  = DP_OFF;
      if (disp_en) begin
         seg_d = mux_pattern ^ SEG_OFF;
         an_d  = (4'b0001 << idx_q) ^ AN_OFF;
         dp_d  = ((idx_q == 2'd2) && colon_on_q) ^ DP_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt_q <= '0;
         idx_q         <= '0;
         colon_cnt_q   <= '0;
         colon_on_q    <= 1'b1;
         state_q       <= CONV_IDLE;
         lat_h_q       <= '0;
         lat_m_q       <= '0;
         work_h_q      <= '0;
         work_m_q      <= '0;
         tens_h_q      <= '0;
         tens_m_q      <= '0;
         dig_h_tens_q  <= '0;
         dig_h_units_q <= '0;
         dig_m_tens_q  <= '0;
         dig_m_units_q <= '0;
         seg_q         <= SEG_OFF;
         dp_q          <= DP_OFF;
         an_q          <= AN_OFF;
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
         refresh_cnt_q <= refresh_cnt_d;
         idx_q         <= idx_d;
         colon_cnt_q   <= colon_cnt_d;
         colon_on_q    <= colon_on_d;
         state_q       <= state_d;
         lat_h_q       <= lat_h_d;
         lat_m_q       <= lat_m_d;
         work_h_q      <= work_h_d;
         work_m_q      <= work_m_d;
         tens_h_q      <= tens_h_d;
         tens_m_q      <= tens_m_d;
         dig_h_tens_q  <= dig_h_tens_d;
         dig_h_units_q <= dig_h_units_d;
         dig_m_tens_q  <= dig_m_tens_d;
         dig_m_units_q <= dig_m_units_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
      end
   end

   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign conv_busy = (state_q != CONV_IDLE);

endmodule

// File: tb/tb_clock_display_driver.sv
// Self-checking bench for clock_display_driver: directed and random frames
// compared against a cycle-indexed arithmetic model of the scanned display.
module tb_clock_display_driver;

   localparam int R = 16;
   localparam int C = 64;
   localparam int F = 4 * R;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] hours_fsm, minutes_fsm;
   logic       disp_en, blink_en, lz_blank;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       conv_busy;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   clock_display_driver #(
      .REFRESH_DIV    (R),
      .COLON_DIV      (C),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hours_fsm   (hours_fsm),
      .minutes_fsm (minutes_fsm),
      .disp_en     (disp_en),
      .blink_en    (blink_en),
      .lz_blank    (lz_blank),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .conv_busy   (conv_busy)
   );

   always #5 clk = ~clk;

   // Number of non-reset rising edges since the last reset sample
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [6:0] digit_pattern(input int d);
      case (d)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Expected {an, seg, dp} after edge k for displayed values h:m
   function automatic logic [11:0] exp_out(input int k, input int h, input int m,
                                           input logic lz, input logic en, input logic colon);
      int s;
      int d;
      logic [6:0] pat;
      logic [3:0] an_e;
      logic dp_e;
      s = ((k - 1) / R) % 4;
      case (s)
         0: d = m % 10;
         1: d = m / 10;
         2: d = h % 10;
         default: d = h / 10;
      endcase
      pat = (s == 3 && lz && (h / 10) == 0) ? 7'h00 : digit_pattern(d);
      an_e = 4'hF;
      an_e[s] = 1'b0;
      dp_e = !(s == 2 && colon);
      if (!en) return 12'hFFF;
      return {an_e, ~pat, dp_e};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step_to(input int k);
      int guard = 0;
      while (cyc != k && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != k) check("step_to", cyc, k);
   endtask

   task automatic check_out(input string tag, input int h, input int m,
                            input logic lz, input logic en);
      check(tag, {an, seg, dp}, exp_out(cyc, h, m, lz, en, 1'b1));
   endtask

   task automatic scan(input string tag, input int h, input int m, input logic lz,
                       input logic en, input int k0, input int from, input int to);
      for (int o = from; o <= to; o++) begin
         step_to(k0 + o);
         check_out($sformatf("%s_o%0d", tag, o), h, m, lz, en);
      end
   endtask

   task automatic align(output int k0);
      int guard = 0;
      while ((cyc % F) != F - 1 && guard < 2 * F) begin
         @(negedge clk);
         guard++;
      end
      check("frame_align", cyc % F, F - 1);
      k0 = cyc + 1;
   endtask

   // Present inputs for the next frame start, check the old display holds and busy length
   task automatic start_frame(input int h, input int m, input logic lz, input logic en,
                              input int old_h, input int old_m, output int k0);
      int busy_cnt = 0;
      align(k0);
      hours_fsm   = 6'(h);
      minutes_fsm = 6'(m);
      lz_blank    = lz;
      disp_en     = en;
      check("busy_before", conv_busy, 1'b0);
      for (int o = 0; o <= 12; o++) begin
         step_to(k0 + o);
         if (conv_busy) busy_cnt++;
         if (o >= 1 && o <= 3) check_out($sformatf("old_o%0d", o), old_h, old_m, lz, en);
      end
      check("busy_min3", busy_cnt >= 3, 1'b1);
      check("busy_max9", busy_cnt <= 9, 1'b1);
      check("busy_done", conv_busy, 1'b0);
   endtask

   initial begin
      int k0;
      int prev_h, prev_m;
      int h, m;
      logic lz, en;
      int cnt, stray;

      rst = 1'b1;
      hours_fsm = '0;
      minutes_fsm = '0;
      disp_en = 1'b1;
      blink_en = 1'b0;
      lz_blank = 1'b0;

      @(negedge clk);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_busy", conv_busy, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      scan("zero", 0, 0, 1'b0, 1'b1, 0, 1, F - 1);

      start_frame(23, 59, 1'b0, 1'b1, 0, 0, k0);
      scan("t2359", 23, 59, 1'b0, 1'b1, k0, 13, F - 1);
      start_frame(63, 0, 1'b0, 1'b1, 23, 59, k0);
      scan("t6300", 63, 0, 1'b0, 1'b1, k0, 13, F - 1);
      start_frame(0, 30, 1'b1, 1'b1, 63, 0, k0);
      scan("t0030lz", 0, 30, 1'b1, 1'b1, k0, 13, F - 1);

      start_frame(5, 12, 1'b0, 1'b1, 0, 30, k0);
      scan("m12", 5, 12, 1'b0, 1'b1, k0, 13, F - 1);
      start_frame(5, 12, 1'b0, 1'b1, 5, 12, k0);
      scan("m12a", 5, 12, 1'b0, 1'b1, k0, 13, 20);
      minutes_fsm = 6'd45;
      scan("m12b", 5, 12, 1'b0, 1'b1, k0, 21, F - 1);
      start_frame(5, 45, 1'b0, 1'b1, 5, 12, k0);
      scan("m45", 5, 45, 1'b0, 1'b1, k0, 13, F - 1);

      prev_h = 5;
      prev_m = 45;
      for (int i = 0; i < 6; i++) begin
         h  = int'($urandom_range(63));
         m  = int'($urandom_range(63));
         lz = 1'($urandom_range(1));
         en = ($urandom_range(3) != 0);
         start_frame(h, m, lz, en, prev_h, prev_m, k0);
         scan($sformatf("rnd%0d", i), h, m, lz, en, k0, 13, F - 1);
         prev_h = h;
         prev_m = m;
      end

      lz_blank = 1'b0;
      disp_en = 1'b1;
      align(k0);
      hours_fsm = 6'd41;
      minutes_fsm = 6'd37;
      step_to(k0 + 3);
      check("busy_in_div", conv_busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", conv_busy, 1'b0);
      check("midrst_out", {an, seg, dp}, 12'hFFF);
      hours_fsm = 6'd18;
      minutes_fsm = 6'd6;
      rst = 1'b0;
      scan("postrst", 0, 0, 1'b0, 1'b1, 0, 1, F - 1);
      start_frame(18, 6, 1'b0, 1'b1, 0, 0, k0);
      scan("t1806", 18, 6, 1'b0, 1'b1, k0, 13, F - 1);

      rst = 1'b1;
      blink_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int f = 0; f < 5; f++) begin
         if (f == 4) blink_en = 1'b0;
         cnt = 0;
         stray = 0;
         for (int e = 1; e <= F; e++) begin
            step_to(f * F + e);
            if (dp === 1'b0) begin
               if (an === 4'b1011) cnt++;
               else stray++;
            end
         end
         check($sformatf("colon_f%0d", f), cnt, (f == 4 || f % 2 == 0) ? R : 0);
         check($sformatf("colon_stray_f%0d", f), stray, 0);
      end
      disp_en = 1'b0;
      for (int e = 1; e <= F; e += 4) begin
         step_to(5 * F + e);
         check($sformatf("dispoff_%0d", e), {an, seg, dp}, 12'hFFF);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
